// File: rtl/pll_mode_sequencer.sv
// Purpose: retunes the fractional system PLL via its Avalon-MM management port on a filtered mode change.
// Latency: 2-flop sync + STABLE_CYCLES filter, then 3 writes with GAP_CYCLES gaps, LOCK_SETTLE, then up to LOCK_TIMEOUT.
// Backpressure: each write holds mgmt_write/address/data until mgmt_waitrequest is low; mode changes wait for IDLE.
module pll_mode_sequencer #(
  parameter int NUM_MODES     = 4,
  parameter int MODE_W        = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GAP_CYCLES    = 3,
  parameter int LOCK_SETTLE   = 64,
  parameter int LOCK_TIMEOUT  = 65536
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [MODE_W-1:0]       mode_sel,
  input  logic [NUM_MODES*32-1:0] frac_table,
  input  logic                    locked,
  input  logic                    mgmt_waitrequest,
  output logic                    mgmt_write,
  output logic [5:0]              mgmt_address,
  output logic [31:0]             mgmt_writedata,
  output logic                    busy,
  output logic                    done,
  output logic [MODE_W-1:0]       active_mode,
  output logic                    bad_mode,
  output logic                    lock_timeout
);

  // pll_cfg register map used by the sequence
  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_FRAC  = 6'd7;

  // One shared down-time counter covers gaps, settle and lock wait
  localparam int CNT_MAX_A = (LOCK_TIMEOUT > LOCK_SETTLE) ? LOCK_TIMEOUT : LOCK_SETTLE;
  localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MODE,
    S_G1,
    S_W_FRAC,
    S_G2,
    S_W_START,
    S_SETTLE,
    S_LOCKWAIT
  } state_t;

  state_t state, state_nxt;

  logic [MODE_W-1:0] mode_meta, mode_sync, mode_prev, mode_filt;
  logic [7:0]        stable_cnt;
  logic              filt_load;
  logic              locked_meta, locked_sync;

  logic [CNT_W-1:0]  seq_cnt;
  logic              cnt_run;
  logic              gap_done, settle_done, wait_expired;
  logic              start, seq_ok, seq_fail;

  logic [MODE_W-1:0] target_mode;
  logic [31:0]       frac_q;

  // Full-range lookup so any mode_sel encoding indexes safely; unused slots read as zero
  logic [31:0] frac_arr [2**MODE_W];

  for (genvar m = 0; m < 2**MODE_W; m++) begin : g_frac
    if (m < NUM_MODES) begin : g_used
      assign frac_arr[m] = frac_table[32*m +: 32];
    end else begin : g_unused
      assign frac_arr[m] = 32'd0;
    end
  end

  function automatic logic mode_ok(input logic [MODE_W-1:0] m);
    return int'(m) < NUM_MODES;
  endfunction

  // Synchronise the asynchronous mode select and lock indication
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_meta   <= '0;
      mode_sync   <= '0;
      locked_meta <= 1'b0;
      locked_sync <= 1'b0;
    end else begin
      mode_meta   <= mode_sel;
      mode_sync   <= mode_meta;
      locked_meta <= locked;
      locked_sync <= locked_meta;
    end
  end

  // Saturating run counter of identical synchronised samples; a run of STABLE_CYCLES commits the mode
  assign filt_load = (stable_cnt == 8'(STABLE_CYCLES));

  // Stability filter, filtered mode and the bad-mode flag that follows each committed value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_prev  <= '0;
      stable_cnt <= 8'd0;
      mode_filt  <= '0;
      bad_mode   <= 1'b0;
    end else begin
      mode_prev <= mode_sync;
      if (mode_sync != mode_prev) begin
        stable_cnt <= 8'd1;
      end else if (stable_cnt < 8'(STABLE_CYCLES)) begin
        stable_cnt <= stable_cnt + 8'd1;
      end
      if (filt_load) begin
        mode_filt <= mode_prev;
        bad_mode  <= !mode_ok(mode_prev);
      end
    end
  end

  // Counter compare points for the timed states
  assign gap_done     = (seq_cnt == CNT_W'(GAP_CYCLES - 1));
  assign settle_done  = (seq_cnt == CNT_W'(LOCK_SETTLE - 1));
  assign wait_expired = (seq_cnt == CNT_W'(LOCK_TIMEOUT - 1));
  assign cnt_run      = (state == S_G1) || (state == S_G2) ||
                        (state == S_SETTLE) || (state == S_LOCKWAIT);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Avalon write outputs; write lines are combinational so reset drops them at once
  always_comb begin
    state_nxt      = state;
    mgmt_write     = 1'b0;
    mgmt_address   = 6'd0;
    mgmt_writedata = 32'd0;
    start          = 1'b0;
    seq_ok         = 1'b0;
    seq_fail       = 1'b0;
    case (state)
      S_IDLE: begin
        if (mode_ok(mode_filt) && (mode_filt != active_mode)) begin
          start     = 1'b1;
          state_nxt = S_W_MODE;
        end
      end
      S_W_MODE: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_MODE;
        mgmt_writedata = 32'd0;
        if (!mgmt_waitrequest) begin
          state_nxt = (GAP_CYCLES == 0) ? S_W_FRAC : S_G1;
        end
      end
      S_G1: begin
        if (gap_done) begin
          state_nxt = S_W_FRAC;
        end
      end
      S_W_FRAC: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_FRAC;
        mgmt_writedata = frac_q;
        if (!mgmt_waitrequest) begin
          state_nxt = (GAP_CYCLES == 0) ? S_W_START : S_G2;
        end
      end
      S_G2: begin
        if (gap_done) begin
          state_nxt = S_W_START;
        end
      end
      S_W_START: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_START;
        mgmt_writedata = 32'd0;
        if (!mgmt_waitrequest) begin
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_done) begin
          state_nxt = S_LOCKWAIT;
        end
      end
      S_LOCKWAIT: begin
        if (locked_sync) begin
          seq_ok    = 1'b1;
          state_nxt = S_IDLE;
        end else if (wait_expired) begin
          seq_fail  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Timer restarts on every state change and only advances in the timed states
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_cnt <= '0;
    end else if (state_nxt != state) begin
      seq_cnt <= '0;
    end else if (cnt_run) begin
      seq_cnt <= seq_cnt + 1'b1;
    end
  end

  // Latch target and fractional word at start; report outcome when the lock wait ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_mode  <= '0;
      frac_q       <= 32'd0;
      active_mode  <= '0;
      done         <= 1'b0;
      lock_timeout <= 1'b0;
    end else begin
      done <= seq_ok;
      if (start) begin
        target_mode  <= mode_filt;
        frac_q       <= frac_arr[mode_filt];
        lock_timeout <= 1'b0;
      end
      if (seq_ok) begin
        active_mode <= target_mode;
      end
      if (seq_fail) begin
        lock_timeout <= 1'b1;
      end
    end
  end

  // Busy covers every non-idle state, so it falls in the same cycle done is high
  assign busy = (state != S_IDLE);

endmodule
